// File: rtl/cu_hmi_tx.sv
// HMI return-path transmitter: header, NBYTES RAM bytes and XOR checksum
// sent as 8N1 UART, LSB first, back-to-back with no inter-byte gap.
module cu_hmi_tx #(
  parameter int unsigned CLKS_PER_BIT = 163,
  parameter int unsigned NBYTES       = 6
) (
  input  logic       clk,
  input  logic       res,
  input  logic       cmd_read,
  input  logic       dev_sel,
  input  logic [4:0] pkt_addr,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] CPB_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  NB     = 4'(NBYTES);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, CHKSTOP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  nxt_q, nxt_d;
  logic [7:0]  csum_q, csum_d;
  logic [4:0]  lat_q, lat_d;
  logic [7:0]  addr_q, addr_d;
  logic        fetch_q, fetch_d;
  logic        chk_q, chk_d;
  logic        last;
  logic        cap;

  assign mem_addr = addr_q;
  assign last     = (baud_q == CPB_M1);
  // RAM data for the fetch is valid on the second cycle of the stop bit
  assign cap      = fetch_q && (baud_q == 16'd1);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    nxt_d   = nxt_q;
    csum_d  = csum_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    fetch_d = fetch_q;
    chk_d   = chk_q;
    txd     = 1'b1;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    if (state_q != IDLE) begin
      baud_d = last ? 16'd0 : baud_q + 16'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (cmd_read && dev_sel) begin
          lat_d   = pkt_addr;
          sh_d    = {3'b101, pkt_addr};
          csum_d  = {3'b101, pkt_addr};
          idx_d   = 4'd0;
          chk_d   = 1'b0;
          baud_d  = 16'd0;
          state_d = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (last) begin
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        txd = sh_q[0];
        if (last) begin
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (chk_q) begin
              state_d = CHKSTOP;
            end else begin
              state_d = STOP;
              fetch_d = (idx_q < NB);
              addr_d  = (idx_q < NB) ? {lat_q, idx_q[2:0]} : addr_q;
            end
          end
        end
      end
      STOP: begin
        if (cap) begin
          nxt_d  = mem_data;
          csum_d = csum_q ^ mem_data;
          idx_d  = idx_q + 4'd1;
        end
        if (last) begin
          state_d = START;
          chk_d   = !fetch_q;
          if (fetch_q) sh_d = cap ? mem_data : nxt_q;
          else         sh_d = csum_q;
        end
      end
      CHKSTOP: begin
        if (last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      nxt_q   <= '0;
      csum_q  <= '0;
      lat_q   <= '0;
      addr_q  <= '0;
      fetch_q <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      nxt_q   <= nxt_d;
      csum_q  <= csum_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      fetch_q <= fetch_d;
      chk_q   <= chk_d;
    end
  end

endmodule

// File: tb/tb_cu_hmi_tx.sv
// Bench for cu_hmi_tx: UART decode of txd against a packet model built
// from the RAM image; a second instance checks bit widths at 163 clk/bit.
module tb_cu_hmi_tx;

  localparam int CPB  = 4;
  localparam int NB   = 6;
  localparam int SCPB = 163;
  localparam int TOT  = (NB + 2) * 10 * CPB;
  localparam int STOT = (NB + 2) * 10 * SCPB;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       cmd_read = 1'b0;
  logic       cmd_read2 = 1'b0;
  logic       dev_sel = 1'b0;
  logic [4:0] pkt_addr = '0;
  logic [7:0] mem_addr, mem_addr2;
  logic [7:0] mem_data = '0;
  logic [7:0] mem_data2 = '0;
  logic       txd, busy, done;
  logic       txd2, busy2, done2;
  logic [7:0] ram [256];

  int vecs = 0;
  int errs = 0;

  cu_hmi_tx #(.CLKS_PER_BIT(CPB), .NBYTES(NB)) u_dut (
    .clk(clk), .res(res), .cmd_read(cmd_read), .dev_sel(dev_sel),
    .pkt_addr(pkt_addr), .mem_addr(mem_addr), .mem_data(mem_data),
    .txd(txd), .busy(busy), .done(done)
  );

  cu_hmi_tx #(.CLKS_PER_BIT(SCPB), .NBYTES(NB)) u_slow (
    .clk(clk), .res(res), .cmd_read(cmd_read2), .dev_sel(dev_sel),
    .pkt_addr(pkt_addr), .mem_addr(mem_addr2), .mem_data(mem_data2),
    .txd(txd2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_data  <= ram[mem_addr];
    mem_data2 <= ram[mem_addr2];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One packet request; abort_k >= 0 pulls reset at that packet cycle.
  task automatic run_pkt(input logic [4:0] a, input bit collide,
                         input int abort_k);
    logic [7:0] exp_b [NB+2];
    logic [7:0] x;
    logic [7:0] rx;
    int b, t, bi;
    exp_b[0] = {3'b101, a};
    x = exp_b[0];
    for (int i = 0; i < NB; i++) begin
      exp_b[i+1] = ram[{a, 3'(i)}];
      x ^= exp_b[i+1];
    end
    exp_b[NB+1] = x;
    dev_sel  = 1'b1;
    pkt_addr = a;
    cmd_read = 1'b1;
    @(negedge clk);
    cmd_read = 1'b0;
    chk("start_latency_txd", 32'(txd), 0);
    chk("start_latency_busy", 32'(busy), 1);
    rx = '0;
    for (int k = 0; k < TOT; k++) begin
      b = k / (10 * CPB);
      t = k % (10 * CPB);
      if (k == abort_k) begin
        res = 1'b0;
        #1;
        chk("rst_mid_txd", 32'(txd), 1);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_done", 32'(done), 0);
        @(negedge clk);
        res = 1'b1;
        return;
      end
      if (collide && k == 100) begin
        cmd_read = 1'b1;
        pkt_addr = 5'd7;
      end
      if (collide && k == 101) begin
        cmd_read = 1'b0;
        pkt_addr = 5'd9;
      end
      if (t % CPB == CPB / 2) begin
        bi = t / CPB;
        if (bi == 0) chk("start_bit", 32'(txd), 0);
        else if (bi == 9) begin
          chk("stop_bit", 32'(txd), 1);
          chk($sformatf("byte%0d", b), 32'(rx), 32'(exp_b[b]));
        end else rx = {txd, rx[7:1]};
      end
      if (t == 9 * CPB && b < NB)
        chk($sformatf("mem_addr%0d", b), 32'(mem_addr), 32'({a, 3'(b)}));
      chk("busy", 32'(busy), 1);
      // done on packet cycle TOT, counting the first start-bit cycle as 1
      chk("done", 32'(done), 32'(k == TOT - 1));
      if (k < TOT - 1) @(negedge clk);
    end
    @(negedge clk);
    chk("after_done_busy", 32'(busy), 0);
    chk("after_done_txd", 32'(txd), 1);
  endtask

  initial begin
    logic [7:0] saved;
    logic [4:0] sa;
    logic       prev;
    int         run, n;
    bit         first, got;

    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < NB; i++) ram[{5'd3, 3'(i)}] = 8'(i + 1);

    // reset held with random inputs
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmd_read = 1'($urandom);
      dev_sel  = 1'($urandom);
      pkt_addr = 5'($urandom);
      #1;
      chk("rst_txd", 32'(txd), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
    end
    @(negedge clk);
    cmd_read = 1'b0;
    res = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_txd", 32'(txd), 1);
      chk("post_rst_busy", 32'(busy), 0);
    end

    // basic packet: row 3 = 01..06, header A3, checksum A4
    run_pkt(5'd3, 1'b0, -1);

    // deselected request
    saved    = mem_addr;
    dev_sel  = 1'b0;
    pkt_addr = 5'd5;
    cmd_read = 1'b1;
    @(negedge clk);
    cmd_read = 1'b0;
    for (int i = 0; i < 3 * CPB; i++) begin
      chk("desel_txd", 32'(txd), 1);
      chk("desel_busy", 32'(busy), 0);
      chk("desel_mem_addr", 32'(mem_addr), 32'(saved));
      @(negedge clk);
    end

    // collision mid-packet, then request in the cycle after done
    run_pkt(5'd3, 1'b1, -1);
    run_pkt(5'd7, 1'b0, -1);

    // reset during d3 of byte 2, then a full packet
    run_pkt(5'($urandom), 1'b0, 2 * 10 * CPB + 4 * CPB + 1);
    chk("rst_recover_busy", 32'(busy), 0);
    run_pkt(5'($urandom), 1'b0, -1);

    // random RAM rows and packet indices
    for (int p = 0; p < 4; p++) begin
      sa = 5'($urandom);
      for (int i = 0; i < NB; i++) ram[{sa, 3'(i)}] = 8'($urandom);
      run_pkt(sa, 1'b0, -1);
    end

    // bit timing at 163 clk/bit; odd index makes d0 of the header 1
    dev_sel   = 1'b1;
    pkt_addr  = 5'($urandom) | 5'd1;
    cmd_read2 = 1'b1;
    @(negedge clk);
    cmd_read2 = 1'b0;
    chk("slow_start_txd", 32'(txd2), 0);
    prev  = txd2;
    run   = 1;
    n     = 1;
    first = 1'b1;
    got   = 1'b0;
    for (int c = 0; c < STOT + 50; c++) begin
      @(negedge clk);
      n++;
      if (txd2 !== prev) begin
        chk("seg_multiple", 32'(run % SCPB), 0);
        if (first) chk("start_width", 32'(run), SCPB);
        first = 1'b0;
        run   = 1;
        prev  = txd2;
      end else run++;
      if (done2) begin
        got = 1'b1;
        break;
      end
    end
    chk("slow_done_seen", 32'(got), 1);
    chk("slow_last_seg", 32'(run % SCPB), 0);
    chk("slow_pkt_len", 32'(n), STOT);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cu_hmi_tx.md
Name: cu_hmi_tx

Overview:
- Return path of the HMI serial link: formats and transmits one result packet when the command decoder issues a read.
- On a read request it frames a header byte, NBYTES data bytes fetched from the TDC result RAM, and an XOR checksum byte.
- All bytes go out as 8N1 UART, LSB first, on txd, toward the host.
- Sits beside the command decoder: consumes its cmd_read, cmd_dev_sel state and pkt_addr outputs.

Parameters:
- CLKS_PER_BIT, 163, clk cycles per UART bit (19200 baud at 3.125 MHz); legal range 2..65535.
- NBYTES, 6, data bytes per packet; legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous active-low reset.
- cmd_read  in  1  one-cycle read request pulse from the command decoder.
- dev_sel  in  1  high while this FPGA is selected; requests are ignored when low.
- pkt_addr  in  5  packet index, sampled with cmd_read.
- mem_addr  out  8  result RAM read address {pkt_lat[4:0], byte_idx[2:0]}.
- mem_data  in  8  result RAM read data, valid 1 cycle after mem_addr.
- txd  out  1  UART serial output, idle high.
- busy  out  1  high while a packet is in progress.
- done  out  1  one-cycle pulse when the packet's last stop bit completes.

Behaviour:
- Reset (res=0, asynchronous):
  - txd=1, busy=0, done=0, mem_addr=0.
  - State IDLE; bit counter, baud counter, byte index and checksum cleared.
  - Reset mid-packet aborts the packet immediately; no partial byte completes.
- States: IDLE, START, DATA, STOP, CHKSTOP (stop bit of the checksum byte), then back to IDLE.
- IDLE:
  - On cmd_read=1 and dev_sel=1, latch pkt_lat=pkt_addr.
  - Load shift register with header {3'b101, pkt_addr}; set checksum = header, byte_idx=0.
  - Next cycle: go to START, busy=1, txd=0.
- Requests that are ignored:
  - cmd_read with dev_sel=0: no action.
  - cmd_read while busy=1: dropped, not queued.
- Bit timing:
  - Each bit, start/data/stop, holds txd for exactly CLKS_PER_BIT cycles.
  - Data bits are sent LSB first.
  - A byte is 10 bit-times: start 0, d0..d7, stop 1.
- Data fetch:
  - On the first cycle of each non-final stop bit, drive mem_addr={pkt_lat, byte_idx}.
  - Capture mem_data on the next cycle into the next-byte register, then checksum ^= captured byte and byte_idx++.
  - byte_idx counts 0..NBYTES-1.
  - After NBYTES data bytes, the next byte is the checksum (no fetch).
- Inter-byte timing: the next start bit follows the stop bit with no idle gap.
- Packet length: (NBYTES+2) bytes, total (NBYTES+2)*10*CLKS_PER_BIT cycles, measured from the first start-bit cycle to the done pulse.
- End of packet:
  - At the final cycle of the checksum stop bit: done=1 for one cycle, busy=0 in the following cycle, txd stays 1, return to IDLE.
  - A new cmd_read is accepted in the cycle after done.
- pkt_addr changing during a packet has no effect (pkt_lat is used).
- Checksum: 8-bit XOR of the header and all data bytes.

Test Plan:
- Reset: hold res=0 with random inputs -> txd=1, busy=0, done=0 throughout; release -> txd stays 1, no activity.
- Basic packet (CLKS_PER_BIT=4, NBYTES=6):
  - Stimulus: RAM row 3 = 01,02,03,04,05,06; pulse cmd_read with dev_sel=1, pkt_addr=3.
  - Required: decoded bytes A3,01,02,03,04,05,06,A4.
  - Required: mem_addr sequence 0x18..0x1D.
  - Required: done exactly 320 cycles after the first start-bit cycle.
- Deselected: cmd_read with dev_sel=0, pkt_addr=5 -> no start bit, busy=0, mem_addr unchanged.
- Busy collision:
  - Stimulus: second cmd_read with pkt_addr=7 mid-packet; pkt_addr input changed to 9.
  - Required: only one packet, header A3, checksum A4; a cmd_read the cycle after done starts a new packet with header A7.
- Reset mid-packet:
  - Stimulus: assert res=0 during data bit d3 of byte 2.
  - Required: txd=1 and busy=0 within the same cycle; after release, the next request sends a full packet from its header.
- Bit timing: with CLKS_PER_BIT=163, every txd level segment measures an exact multiple of 163 cycles and the start-bit width is 163 cycles.
